// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
// load-use hazard detection and a saturating bubble counter.
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [3:0]      id_alu_ctrl,
    input  logic            id_alu_src,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_branch,
    input  logic            stall,
    input  logic            flush,
    input  logic            exm_reg_write,
    input  logic [4:0]      exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            mwb_reg_write,
    input  logic [4:0]      mwb_rd,
    input  logic [XLEN-1:0] mwb_result,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic [4:0]      ex_rd,
    output logic [3:0]      ex_alu_ctrl,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [XLEN-1:0] ex_store_data,
    output logic [XLEN-1:0] ex_branch_target,
    output logic            hazard_stall,
    output logic [15:0]     bubble_count
);

    logic            valid_q, valid_d;
    logic            reg_write_q, reg_write_d;
    logic            mem_read_q, mem_read_d;
    logic            mem_write_q, mem_write_d;
    logic            branch_q, branch_d;
    logic            alu_src_q, alu_src_d;
    logic [4:0]      rd_q, rd_d;
    logic [4:0]      rs1_q, rs1_d;
    logic [4:0]      rs2_q, rs2_d;
    logic [3:0]      alu_ctrl_q, alu_ctrl_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] target_q, target_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [XLEN-1:0] rs2_data_q, rs2_data_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [15:0]     bubble_count_q, bubble_count_d;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    // EX/MEM is the younger producer, so it is checked first; x0 never matches.
    function automatic logic [XLEN-1:0] forward(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] rf_data,
        input logic            exm_we,
        input logic [4:0]      exm_dst,
        input logic [XLEN-1:0] exm_val,
        input logic            mwb_we,
        input logic [4:0]      mwb_dst,
        input logic [XLEN-1:0] mwb_val
    );
        if (exm_we && (exm_dst != 5'd0) && (exm_dst == rs))
            return exm_val;
        else if (mwb_we && (mwb_dst != 5'd0) && (mwb_dst == rs))
            return mwb_val;
        else
            return rf_data;
    endfunction

    always_comb begin
        hazard_stall = valid_q & mem_read_q & (rd_q != 5'd0) & id_valid &
                       ((id_rs1 == rd_q) | (id_rs2 == rd_q));
        fwd_rs1 = forward(rs1_q, rs1_data_q, exm_reg_write, exm_rd, exm_result,
                          mwb_reg_write, mwb_rd, mwb_result);
        fwd_rs2 = forward(rs2_q, rs2_data_q, exm_reg_write, exm_rd, exm_result,
                          mwb_reg_write, mwb_rd, mwb_result);
    end

    always_comb begin
        valid_d        = valid_q;
        reg_write_d    = reg_write_q;
        mem_read_d     = mem_read_q;
        mem_write_d    = mem_write_q;
        branch_d       = branch_q;
        alu_src_d      = alu_src_q;
        rd_d           = rd_q;
        rs1_d          = rs1_q;
        rs2_d          = rs2_q;
        alu_ctrl_d     = alu_ctrl_q;
        pc_d           = pc_q;
        target_d       = target_q;
        rs1_data_d     = rs1_data_q;
        rs2_data_d     = rs2_data_q;
        imm_d          = imm_q;
        bubble_count_d = bubble_count_q;
        // Bubble: flush always wins; a hazard only bubbles when not externally held.
        if (flush || (!stall && hazard_stall)) begin
            valid_d        = 1'b0;
            reg_write_d    = 1'b0;
            mem_read_d     = 1'b0;
            mem_write_d    = 1'b0;
            branch_d       = 1'b0;
            alu_src_d      = 1'b0;
            rd_d           = 5'd0;
            rs1_d          = 5'd0;
            rs2_d          = 5'd0;
            alu_ctrl_d     = 4'd0;
            pc_d           = '0;
            target_d       = '0;
            rs1_data_d     = '0;
            rs2_data_d     = '0;
            imm_d          = '0;
            bubble_count_d = sat_inc(bubble_count_q);
        end else if (!stall) begin
            valid_d     = id_valid;
            reg_write_d = id_reg_write;
            mem_read_d  = id_mem_read;
            mem_write_d = id_mem_write;
            branch_d    = id_branch;
            alu_src_d   = id_alu_src;
            rd_d        = id_rd;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            alu_ctrl_d  = id_alu_ctrl;
            pc_d        = id_pc;
            target_d    = id_pc + id_imm;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            imm_d       = id_imm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q        <= 1'b0;
            reg_write_q    <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            branch_q       <= 1'b0;
            alu_src_q      <= 1'b0;
            rd_q           <= 5'd0;
            rs1_q          <= 5'd0;
            rs2_q          <= 5'd0;
            alu_ctrl_q     <= 4'd0;
            pc_q           <= '0;
            target_q       <= '0;
            rs1_data_q     <= '0;
            rs2_data_q     <= '0;
            imm_q          <= '0;
            bubble_count_q <= 16'd0;
        end else begin
            valid_q        <= valid_d;
            reg_write_q    <= reg_write_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            branch_q       <= branch_d;
            alu_src_q      <= alu_src_d;
            rd_q           <= rd_d;
            rs1_q          <= rs1_d;
            rs2_q          <= rs2_d;
            alu_ctrl_q     <= alu_ctrl_d;
            pc_q           <= pc_d;
            target_q       <= target_d;
            rs1_data_q     <= rs1_data_d;
            rs2_data_q     <= rs2_data_d;
            imm_q          <= imm_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign ex_valid         = valid_q;
    assign ex_reg_write     = reg_write_q;
    assign ex_mem_read      = mem_read_q;
    assign ex_mem_write     = mem_write_q;
    assign ex_branch        = branch_q;
    assign ex_rd            = rd_q;
    assign ex_alu_ctrl      = alu_ctrl_q;
    assign ex_pc            = pc_q;
    assign ex_branch_target = target_q;
    assign bubble_count     = bubble_count_q;
    assign alu_a            = fwd_rs1;
    assign alu_b            = alu_src_q ? imm_q : fwd_rs2;
    assign ex_store_data    = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: reset, forwarding, immediate select,
// load-use bubbles, stall/flush precedence, target wrap and counter saturation.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_ctrl;
    logic        id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_branch;
    logic        stall, flush;
    logic        exm_reg_write, mwb_reg_write;
    logic [4:0]  exm_rd, mwb_rd;
    logic [31:0] exm_result, mwb_result;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_alu_ctrl;
    logic [31:0] ex_pc, alu_a, alu_b, ex_store_data, ex_branch_target;
    logic        hazard_stall;
    logic [15:0] bubble_count;

    int vectors = 0;
    int miscompares = 0;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_ctrl(id_alu_ctrl),
        .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_branch(id_branch), .stall(stall), .flush(flush),
        .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_rd(ex_rd),
        .ex_alu_ctrl(ex_alu_ctrl), .ex_pc(ex_pc), .alu_a(alu_a), .alu_b(alu_b),
        .ex_store_data(ex_store_data), .ex_branch_target(ex_branch_target),
        .hazard_stall(hazard_stall), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_ctrl = 0; id_alu_src = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_branch = 0;
        stall = 0; flush = 0;
        exm_reg_write = 0; exm_rd = 0; exm_result = 0;
        mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
    endtask

    // Advance one edge and settle past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        step();
        vectors++;
        if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", ex_valid); end
        vectors++;
        if (bubble_count !== 16'd0) begin miscompares++; $display("FAIL reset_bubbles got %0d want 0", bubble_count); end
        vectors++;
        if (ex_alu_ctrl !== 4'd0) begin miscompares++; $display("FAIL reset_aluctrl got %0h want 0", ex_alu_ctrl); end
        vectors++;
        if ({alu_a, alu_b, ex_store_data} !== 96'd0) begin miscompares++; $display("FAIL reset_operands got %h %h %h want 0", alu_a, alu_b, ex_store_data); end
        vectors++;
        if (hazard_stall !== 1'b0) begin miscompares++; $display("FAIL reset_hazard got %0b want 0", hazard_stall); end
        rst = 0;
    endtask

    task automatic test_reset_mid_run();
        id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_rd = 3; id_rs1_data = 32'h5;
        id_rs2_data = 32'h6; id_alu_ctrl = 4'h2; id_reg_write = 1; id_pc = 32'h40;
        step();
        vectors++;
        if (ex_valid !== 1'b1 || alu_a !== 32'h5 || ex_alu_ctrl !== 4'h2) begin
            miscompares++; $display("FAIL midrst_load got v=%0b a=%h c=%h want 1 5 2", ex_valid, alu_a, ex_alu_ctrl);
        end
        idle_inputs();
        #2 rst = 1;
        #1;
        vectors++;
        if (ex_valid !== 1'b0 || bubble_count !== 16'd0 || alu_a !== 32'd0) begin
            miscompares++; $display("FAIL midrst_async got v=%0b bc=%0d a=%h want 0 0 0", ex_valid, bubble_count, alu_a);
        end
        #1 rst = 0;
    endtask

    task automatic test_forward();
        idle_inputs();
        id_valid = 1; id_rs1 = 5; id_rs1_data = 32'h33; id_rs2 = 6; id_rs2_data = 32'h44; id_rd = 7;
        step();
        idle_inputs();
        exm_reg_write = 1; exm_rd = 5; exm_result = 32'h11;
        mwb_reg_write = 1; mwb_rd = 5; mwb_result = 32'h22;
        #1;
        vectors++;
        if (alu_a !== 32'h11) begin miscompares++; $display("FAIL fwd_exm_priority got %h want 11", alu_a); end
        exm_reg_write = 0;
        #1;
        vectors++;
        if (alu_a !== 32'h22) begin miscompares++; $display("FAIL fwd_mwb got %h want 22", alu_a); end
        exm_reg_write = 1; exm_rd = 0; mwb_rd = 0;
        #1;
        vectors++;
        if (alu_a !== 32'h33) begin miscompares++; $display("FAIL fwd_x0_none got %h want 33", alu_a); end
        mwb_rd = 6; mwb_result = 32'h66;
        #1;
        vectors++;
        if (alu_b !== 32'h66 || ex_store_data !== 32'h66) begin
            miscompares++; $display("FAIL fwd_rs2 got b=%h sd=%h want 66 66", alu_b, ex_store_data);
        end
    endtask

    task automatic test_imm_select();
        idle_inputs();
        id_valid = 1; id_alu_src = 1; id_imm = 32'hFFFF_FFFC; id_rs2 = 7; id_rs2_data = 32'h0;
        step();
        idle_inputs();
        exm_reg_write = 1; exm_rd = 7; exm_result = 32'h7;
        #1;
        vectors++;
        if (alu_b !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL imm_alu_b got %h want fffffffc", alu_b); end
        vectors++;
        if (ex_store_data !== 32'h7) begin miscompares++; $display("FAIL imm_store got %h want 7", ex_store_data); end
    endtask

    task automatic test_load_use();
        idle_inputs();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 0; id_rs1 = 2;
        step();
        idle_inputs();
        id_valid = 1; id_rs1 = 0; id_rs2 = 0;
        #1;
        vectors++;
        if (hazard_stall !== 1'b0) begin miscompares++; $display("FAIL lu_x0 got %0b want 0", hazard_stall); end
        idle_inputs();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 3; id_rs1 = 2;
        step();
        idle_inputs();
        id_valid = 1; id_rs1 = 3; id_rs2 = 1; id_rd = 4; id_rs2_data = 32'h1; id_reg_write = 1;
        #1;
        vectors++;
        if (hazard_stall !== 1'b1 || bubble_count !== 16'd0) begin
            miscompares++; $display("FAIL lu_detect got hz=%0b bc=%0d want 1 0", hazard_stall, bubble_count);
        end
        step();
        vectors++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || bubble_count !== 16'd1 || hazard_stall !== 1'b0) begin
            miscompares++; $display("FAIL lu_bubble got v=%0b rw=%0b bc=%0d hz=%0b want 0 0 1 0", ex_valid, ex_reg_write, bubble_count, hazard_stall);
        end
        exm_reg_write = 1; exm_rd = 3; exm_result = 32'hABCD;
        step();
        vectors++;
        if (ex_valid !== 1'b1 || ex_rd !== 5'd4 || alu_a !== 32'hABCD || alu_b !== 32'h1) begin
            miscompares++; $display("FAIL lu_resume got v=%0b rd=%0d a=%h b=%h want 1 4 abcd 1", ex_valid, ex_rd, alu_a, alu_b);
        end
    endtask

    task automatic test_stall_flush();
        idle_inputs();
        id_valid = 1; id_rd = 9; id_alu_ctrl = 4'h5; id_pc = 32'h100; id_reg_write = 1;
        step();
        idle_inputs();
        id_valid = 1; id_rd = 12; id_alu_ctrl = 4'hA; id_pc = 32'h200; stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (ex_valid !== 1'b1 || ex_rd !== 5'd9 || ex_alu_ctrl !== 4'h5 || ex_pc !== 32'h100 || ex_reg_write !== 1'b1) begin
                miscompares++; $display("FAIL stall_hold[%0d] got v=%0b rd=%0d c=%h pc=%h want 1 9 5 100", i, ex_valid, ex_rd, ex_alu_ctrl, ex_pc);
            end
        end
        flush = 1;
        step();
        vectors++;
        if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || bubble_count !== 16'd2) begin
            miscompares++; $display("FAIL flush_over_stall got v=%0b bc=%0d want 0 2", ex_valid, bubble_count);
        end
        idle_inputs();
        id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 3;
        step();
        idle_inputs();
        id_valid = 1; id_rs2 = 3; stall = 1;
        #1;
        vectors++;
        if (hazard_stall !== 1'b1) begin miscompares++; $display("FAIL hz_under_stall got %0b want 1", hazard_stall); end
        step();
        vectors++;
        if (bubble_count !== 16'd2 || ex_valid !== 1'b1 || ex_mem_read !== 1'b1) begin
            miscompares++; $display("FAIL hz_stall_hold got bc=%0d v=%0b mr=%0b want 2 1 1", bubble_count, ex_valid, ex_mem_read);
        end
        stall = 0;
        step();
        vectors++;
        if (bubble_count !== 16'd3 || ex_valid !== 1'b0) begin
            miscompares++; $display("FAIL hz_after_stall got bc=%0d v=%0b want 3 0", bubble_count, ex_valid);
        end
    endtask

    task automatic test_wrap_saturate();
        idle_inputs();
        id_valid = 1; id_branch = 1; id_pc = 32'hFFFF_FFF8; id_imm = 32'h10;
        step();
        vectors++;
        if (ex_branch_target !== 32'h0000_0008 || ex_branch !== 1'b1) begin
            miscompares++; $display("FAIL target_wrap got %h br=%0b want 00000008 1", ex_branch_target, ex_branch);
        end
        idle_inputs();
        flush = 1;
        for (int i = 0; i < 65531; i++) @(posedge clk);
        #1;
        vectors++;
        if (bubble_count !== 16'hFFFE) begin miscompares++; $display("FAIL sat_pre got %h want fffe", bubble_count); end
        step();
        vectors++;
        if (bubble_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_reach got %h want ffff", bubble_count); end
        for (int i = 0; i < 5; i++) @(posedge clk);
        #1;
        vectors++;
        if (bubble_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold got %h want ffff", bubble_count); end
        flush = 0;
    endtask

    initial begin
        test_reset();
        test_reset_mid_run();
        test_forward();
        test_imm_select();
        test_load_use();
        test_stall_flush();
        test_wrap_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated operand forwarding and load-use hazard detection. It captures decoded instruction fields from the decode stage on each rising clock edge. It resolves the ALU's two 32-bit operands by forwarding from the EX/MEM and MEM/WB stages, and tells the upstream stages when a load-use bubble is required. Its outputs feed the ALU inputs (`alu_a`, `alu_b`, `ex_alu_ctrl`) and the EX/MEM register.

## Interface
- `XLEN`, 32: datapath width
- `clk` input 1: clock, rising-edge
- `rst` input 1: reset, asynchronous, active-high
- `id_valid` input 1: decode slot holds a real instruction
- `id_pc` input XLEN: instruction PC
- `id_rs1_data`, `id_rs2_data` input XLEN: register-file read data
- `id_imm` input XLEN: sign-extended immediate
- `id_rs1`, `id_rs2`, `id_rd` input 5: register indices
- `id_alu_ctrl` input 4: ALU operation code, passed through unchanged
- `id_alu_src` input 1: 1 selects `imm` for operand B
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_branch` input 1: control bits
- `stall` input 1: external hold (memory wait); freezes this register
- `flush` input 1: squash (taken branch); inserts bubble
- `exm_reg_write` input 1, `exm_rd` input 5, `exm_result` input XLEN: EX/MEM writeback source
- `mwb_reg_write` input 1, `mwb_rd` input 5, `mwb_result` input XLEN: MEM/WB writeback source
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch` output 1: registered controls
- `ex_rd` output 5, `ex_alu_ctrl` output 4, `ex_pc` output XLEN: registered fields
- `alu_a`, `alu_b` output XLEN: forwarded ALU operands (combinational)
- `ex_store_data` output XLEN: forwarded rs2 value for stores
- `ex_branch_target` output XLEN: registered `id_pc + id_imm`
- `hazard_stall` output 1: load-use detected; upstream must hold PC and IF/ID
- `bubble_count` output 16: saturating count of inserted bubbles

## Operation
- Registered state: all `ex_*` outputs, plus internal `rs1`, `rs2`, `rs1_data`, `rs2_data`, `imm`, `alu_src`, and `bubble_count`.
- Reset: every registered field resets to 0, including `ex_alu_ctrl` = 4'b0000 and `bubble_count` = 0. With all sources at 0, `alu_a`, `alu_b`, `ex_store_data` and `hazard_stall` are 0.
- Load-use hazard:
  - `hazard_stall` = `ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((id_rs1 == ex_rd) | (id_rs2 == ex_rd))`.
  - It is combinational and asserts regardless of `stall` and `flush`.
- Update priority at each edge (highest first):
  1. `flush`: bubble.
  2. `stall`: hold all fields, `bubble_count` unchanged.
  3. `hazard_stall`: bubble.
  4. Otherwise: load all `id_*` fields; `ex_valid` = `id_valid`.
- Bubble definition:
  - `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write` and `ex_branch` are cleared.
  - Data fields, indices and `ex_alu_ctrl` are don't-care and are also cleared to 0.
  - `bubble_count` increments by 1 per bubble and saturates at 16'hFFFF.
- Forwarding for rs1 (rs2 identical):
  - If `exm_reg_write & exm_rd != 0 & exm_rd == rs1`, use `exm_result`.
  - Else if `mwb_reg_write & mwb_rd != 0 & mwb_rd == rs1`, use `mwb_result`.
  - Else use `rs1_data`.
  - EX/MEM always wins over MEM/WB.
- Operand outputs:
  - `alu_a` = forwarded rs1.
  - `alu_b` = `alu_src ? imm : forwarded rs2`.
  - `ex_store_data` = forwarded rs2, independent of `alu_src`.
- Register x0 is never forwarded and never raises a hazard.
- `ex_branch_target` is computed at capture, modulo 2^XLEN (wraps, no overflow flag).

## Timing
- Capture latency is 1 cycle: fields presented during cycle N appear on `ex_*` after edge N.
- Forwarding and `hazard_stall` are zero-latency combinational paths. No registers exist on `exm_*`/`mwb_*` to outputs.
- During a hazard, the upstream holds its ID slot. On the next edge the load sits in EX/MEM, `hazard_stall` deasserts, and the held instruction loads with EX/MEM forwarding.
- `stall` and `hazard_stall` together: the register holds, and the hazard is re-evaluated next cycle.
- `flush` and `stall` together: `flush` wins and a bubble is inserted.
- Asserting `rst` mid-operation clears state immediately, without waiting for a clock edge. The first load occurs on the first rising edge after `rst` deasserts.

## Test plan
- Reset mid-run: load a valid add, then assert `rst` between edges → `ex_valid` = 0 and `bubble_count` = 0 immediately; `alu_a` = 0 when `exm`/`mwb` are idle.
- Forward priority: `rs1` = 5; `exm_rd` = 5, `exm_result` = 32'h11; `mwb_rd` = 5, `mwb_result` = 32'h22 (both writing) → `alu_a` = 32'h11. With `exm_reg_write` = 0 → 32'h22. With `exm_rd` = `mwb_rd` = 0 → `rs1_data`.
- Immediate select: `alu_src` = 1, `imm` = 32'hFFFF_FFFC, forwarded rs2 = 32'h7 → `alu_b` = 32'hFFFF_FFFC and `ex_store_data` = 32'h7.
- Load-use: EX holds lw x3, ID holds add x4,x3,x1 → `hazard_stall` = 1 and the next edge inserts a bubble (`bubble_count` 0→1). The following edge loads the add, with `alu_a` forwarded from `exm_result`.
- Stall/flush precedence: `stall` = 1 holds all `ex_*` for 3 cycles. Then `stall` = `flush` = 1 → bubble (`ex_valid` = 0). A hazard under `stall` leaves `bubble_count` unchanged.
- Wrap and saturation: `id_pc` = 32'hFFFF_FFF8, `id_imm` = 32'h10 → `ex_branch_target` = 32'h0000_0008. Force 65,536 bubbles → `bubble_count` = 16'hFFFF, and it stays there.
